// File: rtl/jtbubl_comm_pkg.sv
// Shared constants for the sound-side mailbox: register map, status bits, NMI states.
package jtbubl_comm_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_ACK  = 2'd2;

    localparam int ST_SND  = 0;
    localparam int ST_MAIN = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        WAIT   = 2'd2
    } nmi_st_t;

    function automatic logic [7:0] stat_byte(input logic ovr, input logic mflag, input logic sflag);
        logic [7:0] s;
        s         = '0;
        s[ST_OVR]  = ovr;
        s[ST_MAIN] = mflag;
        s[ST_SND]  = sflag;
        return s;
    endfunction

endpackage

// File: rtl/jtbubl_comm_fifo.sv
// Small synchronous FIFO for queued main-to-sound bytes; caller guards push/pop against full/empty.
module jtbubl_comm_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign dout  = mem[rp];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Sound-CPU end of the main<->sound mailbox: byte capture, NMI generation, reply latch.
// Define JTBUBL_COMM_FIFO_EN to queue incoming bytes in a FIFO_DEPTH FIFO instead of a single latch.
module jtbubl_snd_comm
    import jtbubl_comm_pkg::*;
#(
    parameter int NMI_HOLD   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen3,
    input  logic [7:0] snd_latch,
    input  logic       snd_stb,
    input  logic       main_ack,
    input  logic       cs,
    input  logic       rnw,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       nmi_n,
    output logic [7:0] main_latch,
    output logic       main_stb,
    output logic       main_flag,
    output logic       snd_flag
);

    localparam int CW = $clog2(NMI_HOLD + 1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    logic       acc, rd0, wr0, wr1, wr2;
    logic       stb_l, ack_l, stb_edge, ack_edge;
    logic       nmi_en, overrun, armed;
    logic       ovr_set, arm_set;
    logic [7:0] rd_data;

    assign acc      = cs & cen3;
    assign rd0      = acc &  rnw & (addr == REG_DATA);
    assign wr0      = acc & ~rnw & (addr == REG_DATA);
    assign wr1      = acc & ~rnw & (addr == REG_STAT);
    assign wr2      = acc & ~rnw & (addr == REG_ACK);
    assign stb_edge = snd_stb  & ~stb_l;
    assign ack_edge = main_ack & ~ack_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_l <= 1'b0;
            ack_l <= 1'b0;
        end else begin
            stb_l <= snd_stb;
            ack_l <= main_ack;
        end
    end

`ifdef JTBUBL_COMM_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic          push, pop, full, empty;
    logic [AW:0]   count;
    logic [7:0]    head;

    // a pop frees a slot in the same clk, so a push into a full queue survives a simultaneous read
    assign pop      = rd0 & ~empty;
    assign push     = stb_edge & (~full | pop);
    assign ovr_set  = stb_edge & full & ~pop;
    assign arm_set  = push | (pop & (count > (AW+1)'(1)));
    assign snd_flag = ~empty;
    assign rd_data  = empty ? 8'hFF : head;

    jtbubl_comm_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (snd_latch),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
`else
    logic [7:0] data;
    logic       flag;

    // a capture beats a read in the same clk: the reader sees the old byte, the flag stays set
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= 8'h00;
            flag <= 1'b0;
        end else if (stb_edge) begin
            data <= snd_latch;
            flag <= 1'b1;
        end else if (rd0) begin
            flag <= 1'b0;
        end
    end

    assign ovr_set  = stb_edge & flag;
    assign arm_set  = stb_edge;
    assign snd_flag = flag;
    assign rd_data  = data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            main_latch <= 8'h00;
            main_stb   <= 1'b0;
            main_flag  <= 1'b0;
            nmi_en     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            main_stb <= wr0;
            if (wr0) begin
                main_latch <= din;
                main_flag  <= 1'b1;
            end else if (ack_edge) begin
                main_flag  <= 1'b0;
            end
            if (wr1) nmi_en <= din[0];
            if (ovr_set)          overrun <= 1'b1;
            else if (wr1 && din[1]) overrun <= 1'b0;
        end
    end

    always_comb begin
        dout = 8'hFF;
        case (addr)
            REG_DATA: dout = rd_data;
            REG_STAT: dout = stat_byte(overrun, main_flag, snd_flag);
            default:  ;
        endcase
    end

    nmi_st_t       st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rel_pend, rel_pend_nxt;
    logic          rel, go, hold_done;

    assign rel       = wr2 | rd0;
    assign go        = armed & snd_flag & nmi_en;
    assign hold_done = cen3 && (cnt == CW'(NMI_HOLD - 1));

    // armed makes the NMI edge-style: one NMI per captured byte
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= '0;
            rel_pend <= 1'b0;
            armed    <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            rel_pend <= rel_pend_nxt;
            if (arm_set)                armed <= 1'b1;
            else if (st == IDLE && go)  armed <= 1'b0;
        end
    end

    always_comb begin
        st_nxt       = st;
        cnt_nxt      = cnt;
        rel_pend_nxt = rel_pend;
        case (st)
            IDLE: if (go) begin
                st_nxt       = ASSERT;
                cnt_nxt      = '0;
                rel_pend_nxt = 1'b0;
            end
            ASSERT: begin
                if (rel)  rel_pend_nxt = 1'b1;
                if (cen3) cnt_nxt      = cnt + 1'b1;
                if (hold_done) st_nxt  = (rel_pend | rel) ? IDLE : WAIT;
            end
            WAIT:    if (rel) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    assign nmi_n = (st == IDLE);

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Scoreboard bench for jtbubl_snd_comm: stimulus queues expectations, a negedge monitor checks them.
module tb_jtbubl_snd_comm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen3;
    logic [7:0] snd_latch = 8'h00;
    logic       snd_stb = 1'b0;
    logic       main_ack = 1'b0;
    logic       cs = 1'b0;
    logic       rnw = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       nmi_n;
    logic [7:0] main_latch;
    logic       main_stb;
    logic       main_flag;
    logic       snd_flag;

    logic [2:0] cen_cnt = 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cen_cnt <= cen_cnt + 3'd1;
    assign cen3 = (cen_cnt == 3'd7);

    jtbubl_snd_comm dut (
        .clk        (clk),
        .rst        (rst),
        .cen3       (cen3),
        .snd_latch  (snd_latch),
        .snd_stb    (snd_stb),
        .main_ack   (main_ack),
        .cs         (cs),
        .rnw        (rnw),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .nmi_n      (nmi_n),
        .main_latch (main_latch),
        .main_stb   (main_stb),
        .main_flag  (main_flag),
        .snd_flag   (snd_flag)
    );

    typedef enum int {S_DOUT, S_NMI, S_SFLAG, S_MFLAG, S_MLATCH, S_MSTB} sel_t;
    typedef struct {
        string      name;
        sel_t       sel;
        logic [7:0] exp;
    } chk_t;

    chk_t       ckq[$];
    logic [7:0] mq[$];
    int         total = 0;
    int         bad = 0;
    logic       chk_req = 1'b0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    chk_t       mc;
    logic [7:0] mact;

    always @(negedge clk) begin
        if (chk_req) begin
            if (ckq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: check requested with nothing queued");
            end else begin
                mc = ckq.pop_front();
                case (mc.sel)
                    S_DOUT:   mact = dout;
                    S_NMI:    mact = {7'd0, nmi_n};
                    S_SFLAG:  mact = {7'd0, snd_flag};
                    S_MFLAG:  mact = {7'd0, main_flag};
                    S_MLATCH: mact = main_latch;
                    default:  mact = {7'd0, main_stb};
                endcase
                cmp(mc.name, mact, mc.exp);
            end
        end
        if (main_stb) begin
            if (mq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL main_stb_unexpected: got pulse expected none, latch %0h", main_latch);
            end else begin
                cmp("main_latch_on_stb", main_latch, mq.pop_front());
            end
        end
    end

    // every task below starts and ends 1 time unit after a rising edge
    task automatic expect_sig(input string name, input sel_t sel, input logic [7:0] exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp;
        ckq.push_back(c);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic wait_cen();
        while (!cen3) begin @(posedge clk); #1; end
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        chk_t c;
        wait_cen();
        cs = 1'b1; rnw = 1'b1; addr = a;
        c.name = name; c.sel = S_DOUT; c.exp = exp;
        ckq.push_back(c);
        chk_req = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; chk_req = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        wait_cen();
        cs = 1'b1; rnw = 1'b0; addr = a; din = d;
        if (a == 2'd0) mq.push_back(d);
        @(posedge clk); #1;
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic strobe(input logic [7:0] b);
        snd_latch = b; snd_stb = 1'b1;
        @(posedge clk); #1;
        snd_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic count_nmi_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (!nmi_n) lows++;
        end
    endtask

    task automatic wait_nmi_low(input string name);
        int k;
        k = 0;
        while (nmi_n && k < 20) begin @(posedge clk); #1; k++; end
        cmp(name, nmi_n, 1'b0);
    endtask

    int fall_at, ticks, lows;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        expect_sig("rst_nmi_n",      S_NMI,    8'h01);
        expect_sig("rst_snd_flag",   S_SFLAG,  8'h00);
        expect_sig("rst_main_flag",  S_MFLAG,  8'h00);
        expect_sig("rst_main_latch", S_MLATCH, 8'h00);
        expect_sig("rst_main_stb",   S_MSTB,   8'h00);
        bus_rd(2'd1, 8'h00, "rst_status");
        bus_rd(2'd2, 8'hFF, "rd_addr2");
        bus_rd(2'd3, 8'hFF, "rd_addr3");

        // capture, NMI assertion and hold with an early read
        bus_wr(2'd1, 8'h01);
        fork
            begin
                fall_at = -1; ticks = 0;
                for (int n = 0; n < 300; n++) begin
                    @(negedge clk);
                    if (fall_at < 0 && !nmi_n) fall_at = n;
                    if (fall_at >= 0) begin
                        if (nmi_n) break;
                        if (cen3) ticks++;
                    end
                end
                cmp("nmi_fall_within_tick", (fall_at >= 0 && fall_at <= 10), 1);
                cmp("nmi_hold_ticks", ticks, 8);
            end
            begin
                strobe(8'h5A);
                expect_sig("sflag_after_stb", S_SFLAG, 8'h01);
                bus_rd(2'd0, 8'h5A, "rd_5a");
                expect_sig("sflag_after_rd", S_SFLAG, 8'h00);
            end
        join

        // two captures without a read
        bus_wr(2'd1, 8'h00);
        strobe(8'h11);
        strobe(8'h22);
`ifdef JTBUBL_COMM_FIFO_EN
        bus_rd(2'd1, 8'h01, "stat_two_stb");
        bus_rd(2'd0, 8'h11, "fifo_rd_11");
        bus_rd(2'd0, 8'h22, "fifo_rd_22");
        bus_rd(2'd0, 8'hFF, "fifo_rd_empty");
        bus_rd(2'd1, 8'h00, "stat_drained");
`else
        bus_rd(2'd1, 8'h05, "stat_two_stb");
        bus_rd(2'd0, 8'h22, "rd_overwrite");
        bus_rd(2'd1, 8'h04, "stat_ovr_kept");
`endif
        bus_wr(2'd1, 8'h02);
        bus_rd(2'd1, 8'h00, "stat_ovr_cleared");

        // reply path
        bus_wr(2'd0, 8'hC3);
        expect_sig("mflag_set",     S_MFLAG,  8'h01);
        expect_sig("main_latch_c3", S_MLATCH, 8'hC3);
        main_ack = 1'b1;
        @(posedge clk); #1;
        main_ack = 1'b0;
        expect_sig("mflag_ack_clr", S_MFLAG, 8'h00);

        // capture colliding with a data read
        strobe(8'h33);
        wait_cen();
        snd_latch = 8'h44; snd_stb = 1'b1;
        bus_rd(2'd0, 8'h33, "rd_old_on_collide");
        snd_stb = 1'b0;
        expect_sig("sflag_kept_collide", S_SFLAG, 8'h01);
        bus_rd(2'd0, 8'h44, "rd_new_after_collide");
        expect_sig("sflag_clr_collide", S_SFLAG, 8'h00);
        bus_wr(2'd1, 8'h02);

        // long strobe gives one capture
        snd_latch = 8'h66; snd_stb = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        snd_latch = 8'h77;
        repeat (35) begin @(posedge clk); #1; end
        snd_stb = 1'b0;
        @(posedge clk); #1;
        bus_rd(2'd1, 8'h01, "stat_long_stb");
        bus_rd(2'd0, 8'h66, "rd_long_stb");
        bus_rd(2'd1, 8'h00, "stat_single_capture");

        // write wins over ack in the same clk
        wait_cen();
        main_ack = 1'b1;
        bus_wr(2'd0, 8'h5C);
        main_ack = 1'b0;
        expect_sig("mflag_write_wins", S_MFLAG, 8'h01);

        // reset mid-operation
        bus_wr(2'd1, 8'h01);
        strobe(8'h99);
        wait_nmi_low("nmi_before_rst");
        rst = 1'b1;
        @(posedge clk); #1;
        expect_sig("rst2_nmi_n",      S_NMI,    8'h01);
        expect_sig("rst2_snd_flag",   S_SFLAG,  8'h00);
        expect_sig("rst2_main_flag",  S_MFLAG,  8'h00);
        expect_sig("rst2_main_latch", S_MLATCH, 8'h00);
        expect_sig("rst2_main_stb",   S_MSTB,   8'h00);
        rst = 1'b0;
        count_nmi_low(40, lows);
        cmp("no_nmi_after_rst", lows, 0);
        bus_wr(2'd1, 8'h01);
        count_nmi_low(40, lows);
        cmp("no_stale_nmi", lows, 0);

        // full hold, WAIT, then release by ack write
        strobe(8'hAA);
        wait_nmi_low("nmi_new_stb");
        repeat (80) begin @(posedge clk); #1; end
        expect_sig("nmi_wait_holds", S_NMI, 8'h00);
        bus_wr(2'd2, 8'h00);
        expect_sig("nmi_ack_release", S_NMI, 8'h01);
        bus_rd(2'd0, 8'hAA, "rd_aa");
        count_nmi_low(40, lows);
        cmp("one_nmi_per_byte", lows, 0);

        repeat (4) begin @(posedge clk); #1; end
        cmp("checks_drained", ckq.size(), 0);
        cmp("replies_drained", mq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
